// File: rtl/health_pkg.sv
// Shared types and constants for the health-monitor pulse path.
package health_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [9:0] bpm_t;

  localparam int DEFAULT_SCLK_HZ = 1000;

  typedef enum logic {IDLE, RUN} state_t;

endpackage

// File: rtl/bcd3_to_bin.sv
// Three-digit BCD to binary converter, purely combinational.
// valid drops when any digit is above 9; bin is meaningless then.
module bcd3_to_bin
  import health_pkg::*;
(
  input  logic [3:0] b2,
  input  logic [3:0] b1,
  input  logic [3:0] b0,
  output logic [9:0] bin,
  output logic       valid
);

  bpm_t hund, tens, ones;

  assign hund  = {6'd0, b2};
  assign tens  = {6'd0, b1};
  assign ones  = {6'd0, b0};
  assign bin   = hund * 10'd100 + tens * 10'd10 + ones;
  assign valid = (b2 <= 4'd9) && (b1 <= 4'd9) && (b0 <= 4'd9);

endmodule

// File: rtl/pulse_synth.sv
// Synthetic heartbeat: BCD BPM setting drives a phase accumulator producing beat/pulse.
// All outputs registered; first beat lands ceil(60*CLK_HZ/bpm) edges after entering RUN.
module pulse_synth
  import health_pkg::*;
#(
  parameter int CLK_HZ    = DEFAULT_SCLK_HZ,
  parameter int PULSE_CYC = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       load,
  input  logic [3:0] b2,
  input  logic [3:0] b1,
  input  logic [3:0] b0,
  output logic       pulse,
  output logic       beat,
  output logic       err,
  output logic [9:0] bpm
);

  localparam int THRESH = 60 * CLK_HZ;
  localparam int ACC_W  = $clog2(THRESH + 1000);
  localparam int CNT_W  = $clog2(PULSE_CYC + 1);
  localparam logic [ACC_W-1:0] THRESH_V = ACC_W'(THRESH);
  localparam logic [CNT_W-1:0] PULSE_V  = CNT_W'(PULSE_CYC);

  state_t           state_q, state_d;
  bpm_t             bpm_q, bpm_d, load_bin;
  logic             err_q, err_d, load_valid;
  logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             beat_q, beat_d;
  logic             pulse_q, pulse_d;

  bcd3_to_bin u_bcd (
    .b2    (b2),
    .b1    (b1),
    .b0    (b0),
    .bin   (load_bin),
    .valid (load_valid)
  );

  // A rejected load keeps the previous rate so a bad entry never stalls the beat.
  always_comb begin
    bpm_d = bpm_q;
    err_d = err_q;
    if (load) begin
      err_d = ~load_valid;
      if (load_valid) begin
        bpm_d = load_bin;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (enable)  state_d = RUN;
      RUN:  if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign acc_sum = acc_q + ACC_W'(bpm_q);

  // Leaving RUN (or sitting in IDLE) clears everything; the entry edge itself does not add.
  always_comb begin
    acc_d  = '0;
    cnt_d  = '0;
    beat_d = 1'b0;
    if (state_q == RUN && enable) begin
      if (acc_sum >= THRESH_V) begin
        acc_d  = acc_sum - THRESH_V;
        beat_d = 1'b1;
        cnt_d  = PULSE_V;
      end else begin
        acc_d = acc_sum;
        cnt_d = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
      end
    end
    pulse_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bpm_q   <= '0;
      err_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      beat_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      bpm_q   <= bpm_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;
  assign beat  = beat_q;
  assign err   = err_q;
  assign bpm   = bpm_q;

endmodule

// File: tb/tb_pulse_synth.sv
// Bench for pulse_synth: load table, directed beat-timing sequences and random run
// checked every cycle against a cumulative-phase reference model.
module tb_pulse_synth;

  localparam int CLK_HZ    = 1000;
  localparam int PULSE_CYC = 100;
  localparam int THRESH    = 60 * CLK_HZ;

  logic       clk = 1'b0;
  logic       rst, enable, load;
  logic [3:0] b2, b1, b0;
  logic       pulse, beat, err;
  logic [9:0] bpm;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pulse_synth #(.CLK_HZ(CLK_HZ), .PULSE_CYC(PULSE_CYC)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .load   (load),
    .b2     (b2),
    .b1     (b1),
    .b0     (b0),
    .pulse  (pulse),
    .beat   (beat),
    .err    (err),
    .bpm    (bpm)
  );

  // Reference model: total phase since entering RUN; a beat happens whenever
  // floor(total/THRESH) steps up, and pulse is high within PULSE_CYC edges of the last beat.
  bit         m_run, m_beat, m_pulse, m_err;
  logic [9:0] m_bpm;
  longint     m_total, m_edge, m_last;
  longint     cyc = 0;
  longint     t0 = 0;
  longint     beats_q[$];
  int         pulse_cnt;

  typedef struct {
    logic [3:0] d2, d1, d0;
    int         exp_bpm;
    bit         exp_err;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_beat = 0; m_pulse = 0; m_err = 0; m_bpm = '0;
    m_total = 0; m_edge = 0; m_last = -1;
  endtask

  task automatic model_step();
    longint prev;
    if (!m_run) begin
      if (enable) begin
        m_run = 1; m_total = 0; m_edge = 0; m_last = -1;
      end
      m_beat = 0; m_pulse = 0;
    end else if (!enable) begin
      m_run = 0; m_beat = 0; m_pulse = 0;
    end else begin
      m_edge++;
      prev    = m_total / THRESH;
      m_total = m_total + longint'(m_bpm);
      m_beat  = (m_total / THRESH) != prev;
      if (m_beat) m_last = m_edge;
      m_pulse = (m_last >= 0) && (m_edge - m_last < PULSE_CYC);
    end
    if (load) begin
      if (b2 <= 9 && b1 <= 9 && b0 <= 9) begin
        m_bpm = 10'(int'(b2) * 100 + int'(b1) * 10 + int'(b0));
        m_err = 0;
      end else begin
        m_err = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    chk($sformatf("outs@%0d {pulse,beat,err,bpm}", cyc),
        {pulse, beat, err, bpm}, {m_pulse, m_beat, m_err, m_bpm});
    if (beat === 1'b1) beats_q.push_back(cyc - t0);
    if (pulse === 1'b1) pulse_cnt++;
  endtask

  task automatic do_load(input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0);
    load = 1'b1; b2 = d2; b1 = d1; b0 = d0;
    tick();
    load = 1'b0;
  endtask

  task automatic run_enable(input int n);
    enable = 1'b1;
    tick();
    t0 = cyc;
    beats_q.delete();
    pulse_cnt = 0;
    repeat (n) tick();
  endtask

  task automatic beat_at(input string name, input int idx, input longint exp);
    longint got;
    got = (beats_q.size() > idx) ? beats_q[idx] : -1;
    chk(name, got, exp);
  endtask

  function automatic logic [3:0] rand_digit();
    if ($urandom_range(0, 7) == 0) return 4'($urandom_range(10, 15));
    return 4'($urandom_range(0, 9));
  endfunction

  initial begin
    vecs[0] = '{4'd0, 4'd6,  4'd0,  60,  1'b0};
    vecs[1] = '{4'd0, 4'd7,  4'd2,  72,  1'b0};
    vecs[2] = '{4'd9, 4'd9,  4'd9,  999, 1'b0};
    vecs[3] = '{4'd0, 4'd0,  4'd0,  0,   1'b0};
    vecs[4] = '{4'd1, 4'd2,  4'd3,  123, 1'b0};
    vecs[5] = '{4'd0, 4'd10, 4'd0,  123, 1'b1};
    vecs[6] = '{4'd15,4'd0,  4'd0,  123, 1'b1};
    vecs[7] = '{4'd2, 4'd5,  4'd5,  255, 1'b0};
    vecs[8] = '{4'd0, 4'd0,  4'd12, 255, 1'b1};
    vecs[9] = '{4'd5, 4'd0,  4'd0,  500, 1'b0};

    rst = 1'b1; enable = 1'b0; load = 1'b0; b2 = '0; b1 = '0; b0 = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset pulse", pulse, 0);
    chk("reset beat", beat, 0);
    chk("reset err", err, 0);
    chk("reset bpm", bpm, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      do_load(vecs[i].d2, vecs[i].d1, vecs[i].d0);
      chk($sformatf("table bpm[%0d]", i), bpm, vecs[i].exp_bpm);
      chk($sformatf("table err[%0d]", i), err, vecs[i].exp_err);
    end

    // 060 BPM: beats every 1000 edges, 100-cycle pulses
    do_load(4'd0, 4'd6, 4'd0);
    run_enable(3100);
    chk("060 beat count", beats_q.size(), 3);
    beat_at("060 beat1", 0, 1000);
    beat_at("060 beat2", 1, 2000);
    beat_at("060 beat3", 2, 3000);
    chk("060 pulse cycles", pulse_cnt, 300);
    enable = 1'b0; tick();

    // 072 loaded on the entry edge itself: rate only counts from the next edge
    load = 1'b1; b2 = 4'd0; b1 = 4'd7; b0 = 4'd2; enable = 1'b1;
    tick();
    load = 1'b0;
    t0 = cyc; beats_q.delete(); pulse_cnt = 0;
    repeat (2500) tick();
    beat_at("072 beat1", 0, 834);
    beat_at("072 beat2", 1, 1667);
    beat_at("072 beat3", 2, 2500);
    chk("072 acc after beat3", dut.acc_q, 0);
    enable = 1'b0; tick();

    // Bad digit while running at 060 leaves rate alone
    do_load(4'd0, 4'd6, 4'd0);
    run_enable(1000);
    do_load(4'd0, 4'hA, 4'd0);
    chk("bad load err", err, 1);
    chk("bad load bpm", bpm, 60);
    repeat (1000) tick();
    beat_at("bad load beat2", 1, 2000);
    do_load(4'd0, 4'd9, 4'd0);
    chk("good load err", err, 0);
    chk("good load bpm", bpm, 90);
    enable = 1'b0; tick();

    // 000 BPM never beats
    do_load(4'd0, 4'd0, 4'd0);
    run_enable(70000);
    chk("000 beats", beats_q.size(), 0);
    chk("000 pulse cycles", pulse_cnt, 0);
    enable = 1'b0; tick();

    // 999 BPM: period < pulse width, pulse stays high after edge 61
    do_load(4'd9, 4'd9, 4'd9);
    run_enable(200);
    beat_at("999 beat1", 0, 61);
    chk("999 pulse cycles", pulse_cnt, 140);
    enable = 1'b0; tick();

    // Drop enable mid-pulse, then re-enable restarts phase
    do_load(4'd0, 4'd6, 4'd0);
    run_enable(1050);
    enable = 1'b0; tick();
    chk("drop pulse", pulse, 0);
    chk("drop beat", beat, 0);
    run_enable(1000);
    chk("reenable beats", beats_q.size(), 1);
    beat_at("reenable beat1", 0, 1000);

    // Async reset mid-pulse, with err set beforehand
    do_load(4'd0, 4'hB, 4'd0);
    repeat (20) tick();
    chk("pre-reset pulse", pulse, 1);
    chk("pre-reset err", err, 1);
    #2 rst = 1'b1;
    #1;
    chk("async rst pulse", pulse, 0);
    chk("async rst beat", beat, 0);
    chk("async rst err", err, 0);
    chk("async rst bpm", bpm, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    t0 = cyc; beats_q.delete(); pulse_cnt = 0;
    repeat (2000) tick();
    chk("post-reset beats", beats_q.size(), 0);
    enable = 1'b0; tick();

    // Random loads and enable toggling against the model
    do_load(4'd7, 4'd2, 4'd0);
    enable = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      if ($urandom_range(0, 99) == 0) begin
        load = 1'b1; b2 = rand_digit(); b1 = rand_digit(); b0 = rand_digit();
      end else begin
        load = 1'b0;
      end
      tick();
    end
    load = 1'b0; enable = 1'b0; tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pulse_synth.md
# pulse_synth

Synthetic heartbeat generator for the health monitor. It converts a 3-digit BCD beats-per-minute setting into a periodic pulse train on the `sclk` domain. It is the transmit-side counterpart of `pulse_monitor`, which measures pulses and reports BCD digits. Its `pulse` output drives `pulse_monitor.pulse_in` in place of the sensor, so the monitor/display path can be checked in the lab and on the bench.

## Interface
- `CLK_HZ`, default 1000: frequency of `clk` in Hz; sets the threshold `THRESH = 60*CLK_HZ`.
- `PULSE_CYC`, default 100: width of each output pulse in `clk` cycles (100 ms at 1 kHz); must be ≥1.
- `clk` in 1: single clock (`sclk` from `clkdiv` at top level).
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: high runs the generator; low idles it.
- `load` in 1: one-cycle strobe that samples `b2`, `b1`, `b0`.
- `b2`, `b1`, `b0` in 4 each: BPM setting in BCD (hundreds, tens, ones), 000–999.
- `pulse` out 1: heartbeat pulse, high `PULSE_CYC` cycles per beat.
- `beat` out 1: one-cycle strobe per beat, coincident with the `pulse` rising edge.
- `err` out 1: last load contained a non-BCD digit.
- `bpm` out 10: current binary BPM setting.

## Operation
- Reset values: `bpm`=0, accumulator=0, `pulse`=0, `beat`=0, `err`=0, pulse counter=0, state IDLE.
- Load, accepted in any state:
  - If all digits are ≤9: `bpm` ← `b2*100 + b1*10 + b0` and `err` ← 0.
  - Otherwise: `bpm` is unchanged and `err` ← 1.
  - Both update on the edge that samples `load`=1.
- State IDLE: accumulator held at 0, `pulse`=0, `beat`=0. Goes to RUN on an edge that samples `enable`=1.
- State RUN, phase-accumulator rate generation. Each edge computes `next = acc + bpm`:
  - If `next ≥ THRESH`: `acc` ← `next − THRESH`, `beat` ← 1, pulse counter ← `PULSE_CYC`.
  - Otherwise: `acc` ← `next`, `beat` ← 0, and the pulse counter decrements if nonzero.
- `pulse` is registered and high while the pulse counter is nonzero after the update.
- Goes to IDLE on an edge that samples `enable`=0. On that same edge, accumulator and pulse counter clear and `pulse`/`beat` drop.
- Arithmetic widths: `bpm` 10 bits; accumulator `ACC_W = $clog2(THRESH+1000)` bits, with no overflow possible. Average beat period is exactly `THRESH/bpm` cycles; individual intervals differ by at most 1 cycle.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- First beat after entering RUN (acc=0): edge number `ceil(THRESH/bpm)` counted from the entry edge. `beat` and `pulse` rise on that edge.
- `bpm`=0 in RUN: the accumulator never advances and no beats occur.
- Load mid-run: the new `bpm` is used from the next edge onward. The accumulator is not cleared, so there is no phase reset.
- Beat while a pulse is in progress: the counter reloads to `PULSE_CYC` (retrigger). If the period is shorter than `PULSE_CYC`, `pulse` stays high continuously. Example: 999 BPM at 1 kHz gives a period of ~60 cycles, so `pulse` stays high.
- `enable` and `load` both active on one edge: the `load` update and the state transition both occur. The new `bpm` first adds on the following edge.
- Asynchronous `rst` mid-pulse: outputs go to their reset values immediately, not at the next edge.

## Structure
- Shared package `health_pkg`:
  - `typedef logic [3:0] bcd_t`
  - `typedef logic [9:0] bpm_t`
  - `localparam int DEFAULT_SCLK_HZ = 1000`
  - state enum `{IDLE, RUN}`
- Sub-module `bcd3_to_bin` (combinational): inputs `b2`/`b1`/`b0`; outputs `bin[9:0]` and `valid`. It is reusable by `display_control` test logic.
- Top-level integration: a mode or switch mux selects `pulse_synth.pulse` or `pulse_sensor.pulse` into `pulse_monitor`.

## Test plan
- 060 BPM, CLK_HZ=1000: load, then enable → `beat` on edges 1000, 2000, 3000 after entry; `pulse` high exactly 100 cycles each.
- 072 BPM: beats at edges 834, 1667, 2500 (intervals 834/833/833); accumulator reads 0 after the third beat.
- Load with `b1`=4'hA while running at 060 → `err`=1, `bpm` stays 60, and beat spacing stays 1000. A following valid load of 090 clears `err` → `bpm`=90.
- 000 BPM with `enable` high for 70000 cycles → no `beat`, `pulse` stays 0. 999 BPM → `pulse` continuously high after the first beat at edge 61.
- Drop `enable` 50 cycles into a pulse → `pulse` low on the next edge. Re-enable → first beat again 1000 edges after entry (060 BPM).
- Assert `rst` asynchronously mid-pulse → `pulse`, `beat`, `err` = 0 and `bpm` = 0 before the next edge. After release, no beats occur until a new load.
